// File: rtl/adder_pkg.sv
// Shared definitions for the sequential chunked adder: FSM encoding and chunk width.
package adder_pkg;

    localparam int CHUNK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/plus_adder_4.sv
// 4-bit ripple adder with carry-in and carry-out; the only adder in the datapath.
module plus_adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/seq_wide_adder.sv
// Sequential WIDTH-bit adder that processes one 4-bit chunk per cycle.
// Define SEQ_WIDE_ADDER_OVF_EN to register the signed overflow flag on ovf.
module seq_wide_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t               state, next_state;
    logic [WIDTH-1:0]     a_q, b_q, work_q, work_next;
    logic                 carry_q;
    logic [IDX_W-1:0]     idx;
    logic [CHUNK_W-1:0]   chunk_a, chunk_b, chunk_sum;
    logic                 chunk_cout;
    logic                 accept, last_chunk;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the offering side holds its data stable until that edge, and ready never depends on valid.
    assign accept     = in_valid && in_ready;
    assign last_chunk = (idx == LAST_IDX);
    assign chunk_a    = a_q[idx*CHUNK_W +: CHUNK_W];
    assign chunk_b    = b_q[idx*CHUNK_W +: CHUNK_W];

    plus_adder_4 u_chunk (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_comb begin
        work_next = work_q;
        work_next[idx*CHUNK_W +: CHUNK_W] = chunk_sum;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)     next_state = ADD;
            ADD:     if (last_chunk) next_state = DONE;
            DONE:    if (out_ready)  next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // Visible result (sum/cout) is loaded only on the last chunk, so it holds through ADD and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            work_q    <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                idx     <= '0;
                work_q  <= '0;
            end else if (state == ADD) begin
                work_q  <= work_next;
                carry_q <= chunk_cout;
                idx     <= idx + 1'b1;
                if (last_chunk) begin
                    sum  <= work_next;
                    cout <= chunk_cout;
                end
            end
        end
    end

`ifdef SEQ_WIDE_ADDER_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit: c = a ^ b ^ s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == ADD && last_chunk) begin
            ovf <= chunk_a[CHUNK_W-1] ^ chunk_b[CHUNK_W-1] ^ chunk_sum[CHUNK_W-1] ^ chunk_cout;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_wide_adder.sv
// Self-checking bench for seq_wide_adder: behavioural model plus directed literal cases (WIDTH 16 and 4).
module tb_seq_wide_adder;

    localparam int W  = 16;
    localparam int N  = W / 4;

`ifdef SEQ_WIDE_ADDER_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;

    logic         in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4;
    logic [3:0]   a4, b4, sum4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_wide_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    seq_wide_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference result {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                                  input logic c);
        logic [W:0] full;
        longint     s;
        logic       o;
        full = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        o = OVF_ON && ((s > (64'sd1 <<< (W-1)) - 1) || (s < -(64'sd1 <<< (W-1))));
        return {o, full};
    endfunction

    // Behavioural model: accept when ready, result visible N edges later, held until taken.
    bit           m_ready, m_valid;
    int           m_cnt;
    logic [W-1:0] m_sum;
    logic         m_cout, m_ovf;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 0; m_valid = 0; m_cnt = 0;
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
            exp_q.delete();
        end else if (m_ready && in_valid) begin
            exp_q.push_back(model_result(a, b, cin));
            m_ready = 0;
            m_cnt = N;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                r = exp_q.pop_front();
                {m_ovf, m_cout, m_sum} = r;
                m_valid = 1;
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 0;
                m_ready = 1;
            end
        end else begin
            m_ready = 1;
        end
        #1;
        check("in_ready", in_ready, m_ready);
        check("out_valid", out_valid, m_valid);
        check("sum", sum, m_sum);
        check("cout", cout, m_cout);
        check("ovf", ovf, m_ovf);
    end

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input int hold, output logic [W-1:0] rs, output logic rc, output logic ro);
        int g;
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_; cin = tc;
        g = 0;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("accept_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("result_wait", out_valid, 1);
        rs = sum; rc = cout; ro = ovf;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_sum", sum, rs);
            check("hold_cout", cout, rc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
    endtask

    task automatic send4(input logic [3:0] x, input logic [3:0] y, input logic c,
                         output logic [3:0] rs, output logic rc, output logic ro, output int lat);
        int n;
        @(negedge clk);
        in_valid4 = 1'b1; a4 = x; b4 = y; cin4 = c;
        n = 0;
        while (!in_ready4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w4_accept_wait", in_ready4, 1);
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(negedge clk);
            in_valid4 = 1'b0; a4 = 4'($urandom);
            lat++;
        end
        lat = lat - 1;
        rs = sum4; rc = cout4; ro = ovf4;
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rc, ro;
        logic [3:0]   rs4;
        logic [4:0]   f4;
        logic [3:0]   x4, y4;
        logic         c4, o4;
        int           lat, s4;

        in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 0;
        in_valid4 = 0; a4 = '0; b4 = '0; cin4 = 0; out_ready4 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_first_edge", in_ready, 0);
        @(posedge clk);
        #2 check("ready_after_first_edge", in_ready, 1);

        send(16'hFFFF, 16'h0001, 1'b0, 0, rs, rc, ro);
        check("wrap_sum", rs, 16'h0000);
        check("wrap_cout", rc, 1);
        check("wrap_ovf", ro, 0);

        send(16'h7FFF, 16'h0001, 1'b0, 0, rs, rc, ro);
        check("pos_ovf_sum", rs, 16'h8000);
        check("pos_ovf_cout", rc, 0);
        check("pos_ovf_ovf", ro, OVF_ON);

        send(16'h0000, 16'h0000, 1'b1, 0, rs, rc, ro);
        check("cin_only_sum", rs, 16'h0001);
        check("cin_only_cout", rc, 0);

        send(16'h1234, 16'h4321, 1'b0, 5, rs, rc, ro);
        check("backpressure_sum", rs, 16'h5555);
        check("backpressure_cout", rc, 0);

        // Abort after two ADD cycles.
        @(negedge clk);
        in_valid = 1'b1; a = 16'hABCD; b = 16'h1111; cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2 check("abort_ready_after_release", in_ready, 1);
        repeat (6) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end

        for (int t = 0; t < 40; t++) begin
            send(pick(), pick(), 1'($urandom), $urandom_range(0, 3), rs, rc, ro);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        send4(4'b1111, 4'b0001, 1'b0, rs4, rc, ro, lat);
        check("w4_latency", 64'(lat), 1);
        check("w4_wrap_sum", rs4, 4'b0000);
        check("w4_wrap_cout", rc, 1);
        check("w4_wrap_ovf", ro, 0);

        for (int t = 0; t < 10; t++) begin
            x4 = 4'($urandom); y4 = 4'($urandom); c4 = 1'($urandom);
            f4 = {1'b0, x4} + {1'b0, y4} + 5'(c4);
            s4 = int'($signed(x4)) + int'($signed(y4)) + int'(c4);
            o4 = OVF_ON && (s4 > 7 || s4 < -8);
            send4(x4, y4, c4, rs4, rc, ro, lat);
            check("w4_rand_latency", 64'(lat), 1);
            check("w4_rand_sum", rs4, f4[3:0]);
            check("w4_rand_cout", rc, f4[4]);
            check("w4_rand_ovf", ro, o4);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_wide_adder.md
SEQ_WIDE_ADDER -- requirements
Module: seq_wide_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 and at least 4.
REQ-002 SHALL have derived constant NCHUNK = WIDTH/4, the number of 4-bit chunks.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: operand set offered.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept an operand set.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-008 SHALL have port cin, input, 1 bit: carry-in.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port sum, output, WIDTH bits: a+b+cin modulo 2^WIDTH.
REQ-012 SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-013 SHALL have port ovf, output, 1 bit: two's-complement overflow flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, ADD, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: when in_valid and in_ready are both 1, SHALL capture a, b and cin, clear chunk index idx to 0, load carry register with cin, and go to ADD.
REQ-016 ADD: each cycle SHALL add chunk idx (bits 4*idx+3..4*idx) of a and b plus the carry register, write the 4-bit result into the sum register at the same position, load the chunk carry-out into the carry register, and increment idx.
REQ-017 ADD: when idx equals NCHUNK-1 the FSM SHALL go to DONE; cout SHALL equal the final chunk carry-out.
REQ-018 Latency SHALL be exactly NCHUNK cycles from the accepting edge to the first cycle in which out_valid is 1.
REQ-019 DONE: out_valid SHALL be 1, and sum, cout and ovf SHALL hold stable until out_ready is 1.
REQ-020 DONE with out_ready=1 SHALL return to IDLE on that edge and clear out_valid.
REQ-021 in_valid SHALL be ignored in ADD and DONE; captured operands SHALL be unaffected by input changes after acceptance.
REQ-022 sum, cout and ovf SHALL retain the last result in IDLE until the next DONE.
REQ-023 When WIDTH=4 (NCHUNK=1), the block SHALL spend one ADD cycle and then go to DONE.
REQ-024 Arithmetic SHALL be unsigned modulo 2^WIDTH; wrap-around (e.g. all-ones + 1) SHALL give sum 0 and cout 1.

Reset
REQ-025 While rst_n is 0: state SHALL be IDLE; in_ready, out_valid, sum, cout, ovf, idx and the carry register SHALL be 0.
REQ-026 in_ready SHALL become 1 on the first rising clk edge after rst_n rises.
REQ-027 Asserting rst_n during ADD or DONE SHALL abort the operation immediately; no out_valid SHALL be produced for the aborted operands.

Configuration
REQ-028 Macro SEQ_WIDE_ADDER_OVF_EN defined: ovf SHALL be registered in DONE as carry-into-MSB XOR cout, i.e. signed overflow of a+b+cin.
REQ-029 Macro SEQ_WIDE_ADDER_OVF_EN undefined: the ovf port SHALL remain present and be tied to 0, with no overflow logic.

Structure
REQ-030 A shared package adder_pkg SHALL hold the FSM state encoding (IDLE/ADD/DONE) and the CHUNK_W=4 constant.
REQ-031 The per-cycle chunk addition SHALL instantiate the existing 4-bit plus_adder_4 as the only sub-module; no other adder SHALL be inferred.

Verification
REQ-032 WIDTH=16, a=16'hFFFF, b=16'h0001, cin=0 -> after 4 cycles: out_valid=1, sum=16'h0000, cout=1, ovf=0.
REQ-033 WIDTH=16, a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0; ovf=1 with the macro defined, ovf=0 without it.
REQ-034 WIDTH=16, a=0, b=0, cin=1 -> sum=16'h0001, cout=0.
REQ-035 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout stay stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE on the next edge.
REQ-036 Pull rst_n low after 2 ADD cycles -> all outputs go to 0 immediately; in_ready=1 one edge after release; out_valid is never asserted.
REQ-037 WIDTH=4, a=4'b1111, b=4'b0001, cin=0 -> out_valid after 1 cycle, sum=4'b0000, cout=1.
